spi_flash_rd: RTL and testbench

SPI flash read engine on the instruction-fetch path, directly downstream of the boot controller's bus-side handshake port. It turns each 32-bit word-read handshake into a standard SPI READ (0x03) transaction on an external serial NOR flash and returns the assembled word. It is read-only: write handshakes are acknowledged without SPI traffic.

---
 rtl/spi_flash_rd.sv | 131 +++++++++++++
 tb/tb_spi_flash_rd.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd.sv
// SPI NOR flash word-read engine: turns a bus word-read handshake into a 0x03 READ
// transaction and returns the little-endian word; writes are acknowledged without SPI traffic.
module spi_flash_rd #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hs_rd_i,
  input  logic        hs_wr_i,
  input  logic [31:0] hs_addr_i,
  input  logic [31:0] hs_data_i,
  output logic        hs_ready_o,
  output logic [31:0] hs_data_o,
  output logic        spi_cs_n_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [1:0]  state_r;
  logic [31:0] tx_r;
  logic [31:0] rx_r;
  logic [5:0]  bit_r;
  logic [7:0]  div_r;
  logic [7:0]  gap_r;
  logic [31:0] cmd_s;
  logic        unused_s;

  // First received byte lands in the least significant lane.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    swap_bytes = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign cmd_s    = {8'h03, hs_addr_i[23:2], 2'b00};
  assign unused_s = ^{hs_data_i, hs_addr_i[31:24], hs_addr_i[1:0]};

  // Transaction sequencer: request decode, SCK phase timing, shift registers, CS recovery.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= S_IDLE;
      tx_r       <= 32'h0000_0000;
      rx_r       <= 32'h0000_0000;
      bit_r      <= 6'd0;
      div_r      <= 8'd0;
      gap_r      <= 8'd0;
      hs_ready_o <= 1'b0;
      hs_data_o  <= 32'h0000_0000;
      spi_cs_n_o <= 1'b1;
      spi_sck_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
    end else begin
      hs_ready_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (hs_rd_i) begin
            tx_r       <= cmd_s;
            spi_mosi_o <= cmd_s[31];
            bit_r      <= 6'd0;
            div_r      <= 8'd0;
            spi_cs_n_o <= 1'b0;
            state_r    <= S_SHIFT;
          end else if (hs_wr_i) begin
            hs_ready_o <= 1'b1;
            state_r    <= S_DONE;
          end else begin
            state_r    <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (div_r == DIV_LAST) begin
            div_r <= 8'd0;
            if (!spi_sck_o) begin
              spi_sck_o <= 1'b1;
              // Only the 32 data bits after command+address are kept.
              if (bit_r[5]) begin
                rx_r <= {rx_r[30:0], spi_miso_i};
              end else begin
                rx_r <= rx_r;
              end
            end else begin
              spi_sck_o <= 1'b0;
              if (bit_r == 6'd63) begin
                spi_cs_n_o <= 1'b1;
                spi_mosi_o <= 1'b0;
                hs_ready_o <= 1'b1;
                hs_data_o  <= swap_bytes(rx_r);
                state_r    <= S_DONE;
              end else begin
                bit_r      <= bit_r + 6'd1;
                tx_r       <= {tx_r[30:0], 1'b0};
                spi_mosi_o <= tx_r[30];
              end
            end
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        S_DONE: begin
          // DONE itself counts as the first chip-select recovery cycle.
          if (GAP_LAST == 8'd0) begin
            state_r <= S_IDLE;
          end else begin
            gap_r   <= 8'd1;
            state_r <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_r >= GAP_LAST) begin
            gap_r   <= 8'd0;
            state_r <= S_IDLE;
          end else begin
            gap_r   <= gap_r + 8'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Directed bench for spi_flash_rd: two instances (CLK_DIV=2 and CLK_DIV=1) each driven
// against a behavioural mode-0 serial flash returning a programmable 4-byte response.
module tb_spi_flash_rd;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;

  // Instance A: CLK_DIV=2, CS_GAP=4
  logic        rd_a, wr_a, ready_a, cs_a, sck_a, mosi_a, miso_a;
  logic [31:0] addr_a, wdata_a, data_a;
  // Instance B: CLK_DIV=1, CS_GAP=4
  logic        rd_b, wr_b, ready_b, cs_b, sck_b, mosi_b, miso_b;
  logic [31:0] addr_b, wdata_b, data_b;

  spi_flash_rd #(.CLK_DIV(2), .CS_GAP(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .hs_rd_i(rd_a), .hs_wr_i(wr_a), .hs_addr_i(addr_a),
    .hs_data_i(wdata_a), .hs_ready_o(ready_a), .hs_data_o(data_a), .spi_cs_n_o(cs_a),
    .spi_sck_o(sck_a), .spi_mosi_o(mosi_a), .spi_miso_i(miso_a));

  spi_flash_rd #(.CLK_DIV(1), .CS_GAP(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .hs_rd_i(rd_b), .hs_wr_i(wr_b), .hs_addr_i(addr_b),
    .hs_data_i(wdata_b), .hs_ready_o(ready_b), .hs_data_o(data_b), .spi_cs_n_o(cs_b),
    .spi_sck_o(sck_b), .spi_mosi_o(mosi_b), .spi_miso_i(miso_b));

  always #5 clk = ~clk;

  // Flash models: capture the first 32 MOSI bits on SCK rise, drive MISO after SCK fall.
  int          cnt_a, k_a, cnt_b, k_b;
  logic [31:0] cmd_a, cmd_b;
  logic [7:0]  bytes_a [4];
  logic [7:0]  bytes_b [4];

  always @(negedge cs_a) begin cnt_a = 0; cmd_a = 32'h0; miso_a = 1'b0; end
  always @(posedge sck_a) if (!cs_a) begin
    if (cnt_a < 32) cmd_a = {cmd_a[30:0], mosi_a};
    cnt_a = cnt_a + 1;
  end
  always @(negedge sck_a) if (!cs_a) begin
    k_a = cnt_a - 32;
    if (k_a >= 0 && k_a < 32) miso_a = bytes_a[k_a / 8][7 - (k_a % 8)];
    else miso_a = 1'b0;
  end

  always @(negedge cs_b) begin cnt_b = 0; cmd_b = 32'h0; miso_b = 1'b0; end
  always @(posedge sck_b) if (!cs_b) begin
    if (cnt_b < 32) cmd_b = {cmd_b[30:0], mosi_b};
    cnt_b = cnt_b + 1;
  end
  always @(negedge sck_b) if (!cs_b) begin
    k_b = cnt_b - 32;
    if (k_b >= 0 && k_b < 32) miso_b = bytes_b[k_b / 8][7 - (k_b % 8)];
    else miso_b = 1'b0;
  end

  // Issue one read on A; cycle 1 is the cycle after the sampling edge. No checks here.
  task automatic run_read_a(input logic [31:0] addr, output int lat, output int rises,
                            output int first_rise, output int cs_hi);
    int n;
    logic prev;
    rd_a = 1'b1; addr_a = addr;
    @(posedge clk); #1;
    n = 1; rises = 0; first_rise = 0; cs_hi = 0; prev = sck_a;
    while (!ready_a && n < 600) begin
      if (cs_a) cs_hi++;
      if (sck_a && !prev) begin
        rises++;
        if (first_rise == 0) first_rise = n;
      end
      prev = sck_a;
      @(posedge clk); #1;
      n++;
    end
    rd_a = 1'b0;
    lat = ready_a ? n : -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_a); end
    total++; if (data_a !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", data_a); end
    total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b want=1", cs_a); end
    total++; if (sck_a !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", sck_a); end
    total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi_a); end
    total++; if (cs_b !== 1'b1) begin bad++; $display("FAIL reset_cs_b got=%b want=1", cs_b); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int lat, rises, first, cs_hi;
    bytes_a[0] = 8'hEF; bytes_a[1] = 8'hBE; bytes_a[2] = 8'hAD; bytes_a[3] = 8'hDE;
    run_read_a(32'h0000_1234, lat, rises, first, cs_hi);
    total++; if (lat !== 257) begin bad++; $display("FAIL read_latency got=%0d want=257", lat); end
    total++; if (data_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got=%h want=deadbeef", data_a); end
    total++; if (cmd_a !== 32'h0300_1234) begin bad++; $display("FAIL read_mosi got=%h want=03001234", cmd_a); end
    total++; if (rises !== 64) begin bad++; $display("FAIL read_sck_rises got=%0d want=64", rises); end
    total++; if (first !== 3) begin bad++; $display("FAIL read_first_rise got=%0d want=3", first); end
    total++; if (cs_hi !== 0) begin bad++; $display("FAIL read_cs_low got=%0d high cycles want=0", cs_hi); end
    total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL read_cs_done got=%b want=1", cs_a); end
    @(posedge clk); #1;
    total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL read_pulse_width got=%b want=0", ready_a); end
    total++; if (data_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data_hold got=%h want=deadbeef", data_a); end
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic test_align;
    int lat, rises, first, cs_hi;
    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33; bytes_a[3] = 8'h44;
    run_read_a(32'hFF00_0007, lat, rises, first, cs_hi);
    total++; if (cmd_a !== 32'h0300_0004) begin bad++; $display("FAIL align_mosi got=%h want=03000004", cmd_a); end
    total++; if (data_a !== 32'h4433_2211) begin bad++; $display("FAIL align_data got=%h want=44332211", data_a); end
    total++; if (lat !== 257) begin bad++; $display("FAIL align_latency got=%0d want=257", lat); end
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic test_write;
    int cs_low, extra;
    wr_a = 1'b1; wdata_a = 32'h1234_5678;
    @(posedge clk); #1;
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL write_ready got=%b want=1", ready_a); end
    total++; if (data_a !== 32'h4433_2211) begin bad++; $display("FAIL write_data_kept got=%h want=44332211", data_a); end
    wr_a = 1'b0;
    cs_low = (cs_a !== 1'b1) ? 1 : 0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cs_a !== 1'b1) cs_low++;
      if (ready_a === 1'b1) extra++;
    end
    total++; if (cs_low !== 0) begin bad++; $display("FAIL write_cs got=%0d low cycles want=0", cs_low); end
    total++; if (extra !== 0) begin bad++; $display("FAIL write_single_pulse got=%0d extra want=0", extra); end
  endtask

  // B holds rd across two reads: ready at 129, IDLE at 133 (DONE+3 GAP), next cs fall 134, ready 262.
  task automatic test_back_to_back;
    int r1, r2, fall, cnt;
    logic [31:0] d1;
    bytes_b[0] = 8'h78; bytes_b[1] = 8'h56; bytes_b[2] = 8'h34; bytes_b[3] = 8'h12;
    r1 = 0; r2 = 0; fall = 0; cnt = 0; d1 = 32'h0;
    rd_b = 1'b1; addr_b = 32'h0000_0100;
    @(posedge clk); #1;
    for (int n = 1; n <= 300; n++) begin
      if (ready_b === 1'b1) begin
        cnt++;
        if (r1 == 0) begin r1 = n; d1 = data_b; end
        else begin r2 = n; rd_b = 1'b0; end
      end
      if (r1 != 0 && fall == 0 && n > r1 && cs_b === 1'b0) fall = n;
      @(posedge clk); #1;
    end
    rd_b = 1'b0;
    total++; if (r1 !== 129) begin bad++; $display("FAIL b2b_first_ready got=%0d want=129", r1); end
    total++; if (d1 !== 32'h1234_5678) begin bad++; $display("FAIL b2b_data got=%h want=12345678", d1); end
    total++; if (fall !== 134) begin bad++; $display("FAIL b2b_cs_gap got=%0d want=134", fall); end
    total++; if (r2 !== 262) begin bad++; $display("FAIL b2b_second_ready got=%0d want=262", r2); end
    total++; if (cnt !== 2) begin bad++; $display("FAIL b2b_pulse_count got=%0d want=2", cnt); end
  endtask

  // A holds rd past ready; it is dropped mid-way through the second transfer, which must still finish.
  task automatic test_held_request;
    int r1, r2, fall, cnt;
    bytes_a[0] = 8'h01; bytes_a[1] = 8'h23; bytes_a[2] = 8'h45; bytes_a[3] = 8'h67;
    r1 = 0; r2 = 0; fall = 0; cnt = 0;
    rd_a = 1'b1; addr_a = 32'h0000_0040;
    @(posedge clk); #1;
    for (int n = 1; n <= 560; n++) begin
      if (ready_a === 1'b1) begin
        cnt++;
        if (r1 == 0) r1 = n; else r2 = n;
      end
      if (r1 != 0 && fall == 0 && n > r1 && cs_a === 1'b0) fall = n;
      if (n == 300) rd_a = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (r1 !== 257) begin bad++; $display("FAIL held_first_ready got=%0d want=257", r1); end
    total++; if (fall !== 262) begin bad++; $display("FAIL held_cs_gap got=%0d want=262", fall); end
    total++; if (r2 !== 518) begin bad++; $display("FAIL held_second_ready got=%0d want=518", r2); end
    total++; if (cnt !== 2) begin bad++; $display("FAIL held_pulse_count got=%0d want=2", cnt); end
    total++; if (data_a !== 32'h6745_2301) begin bad++; $display("FAIL held_data got=%h want=67452301", data_a); end
  endtask

  task automatic test_reset_mid;
    int lat, rises, first, cs_hi;
    rd_a = 1'b1; addr_a = 32'h0000_0200;
    @(posedge clk); #1;
    repeat (99) begin @(posedge clk); #1; end
    rst = 1'b1; rd_a = 1'b0;
    @(posedge clk); #1;
    total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL rstmid_cs got=%b want=1", cs_a); end
    total++; if (sck_a !== 1'b0) begin bad++; $display("FAIL rstmid_sck got=%b want=0", sck_a); end
    total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", ready_a); end
    total++; if (data_a !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=00000000", data_a); end
    rst = 1'b0;
    @(posedge clk); #1;
    bytes_a[0] = 8'hEF; bytes_a[1] = 8'hBE; bytes_a[2] = 8'hAD; bytes_a[3] = 8'hDE;
    run_read_a(32'h0000_1234, lat, rises, first, cs_hi);
    total++; if (lat !== 257) begin bad++; $display("FAIL rstmid_fresh_latency got=%0d want=257", lat); end
    total++; if (data_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rstmid_fresh_data got=%h want=deadbeef", data_a); end
    total++; if (rises !== 64) begin bad++; $display("FAIL rstmid_fresh_rises got=%0d want=64", rises); end
  endtask

  initial begin
    rst = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
    cnt_a = 0; cmd_a = 32'h0; miso_a = 1'b0; k_a = 0;
    cnt_b = 0; cmd_b = 32'h0; miso_b = 1'b0; k_b = 0;
    for (int i = 0; i < 4; i++) begin bytes_a[i] = 8'h00; bytes_b[i] = 8'h00; end
    test_reset();
    test_read();
    test_align();
    test_write();
    test_back_to_back();
    test_held_request();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
